// File: rtl/rename_regfile_mp_pkg.sv
// Shared types and width helpers for the rename register file and its query ports.
// Tags are {busy, rob_pos}; an all-zero tag means the committed value is ready.
package rename_regfile_mp_pkg;

  localparam logic TAG_BUSY = 1'b1;

  typedef enum logic [0:0] {
    DUMP_IDLE = 1'b0,
    DUMP_RUN  = 1'b1
  } dump_state_e;

  function automatic int tag_width(input int rob_pos_w);
    return rob_pos_w + 32'sd1;
  endfunction

  function automatic int reg_pos_width(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/rename_regfile_rdport.sv
// One operand query port: same-cycle renames from older lanes, then retiring results,
// then the committed table; register 0 always reads as ready zero.
module rename_regfile_rdport
  import rename_regfile_mp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 5,
  parameter int ROB_POS_W = 4,
  parameter int NISSUE    = 2,
  parameter int NCOMMIT   = 2,
  parameter int LANE      = 0,
  localparam int TAG_W    = tag_width(ROB_POS_W)
) (
  input  logic [IDX_W-1:0]             rs_i,
  input  logic [DATA_W-1:0]            tbl_val_i,
  input  logic [TAG_W-1:0]             tbl_tag_i,
  input  logic [NISSUE-1:0]            issue_i,
  input  logic [NISSUE*IDX_W-1:0]      issue_rd_i,
  input  logic [NISSUE*ROB_POS_W-1:0]  issue_rob_pos_i,
  input  logic [NCOMMIT-1:0]           cmt_hit_i,
  input  logic [NCOMMIT*IDX_W-1:0]     commit_rd_i,
  input  logic [NCOMMIT*DATA_W-1:0]    commit_val_i,
  output logic [DATA_W-1:0]            val_o,
  output logic [TAG_W-1:0]             tag_o
);

  logic iss_match_s;
  logic cmt_match_s;

  // Rules applied lowest priority first; each later match overrides the earlier result.
  always_comb begin
    val_o       = tbl_val_i;
    tag_o       = tbl_tag_i;
    iss_match_s = 1'b0;
    cmt_match_s = 1'b0;
    for (int c = 0; c < NCOMMIT; c++) begin
      cmt_match_s = cmt_hit_i[c] && (commit_rd_i[c*IDX_W +: IDX_W] == rs_i);
      val_o = cmt_match_s ? commit_val_i[c*DATA_W +: DATA_W] : val_o;
      tag_o = cmt_match_s ? {TAG_W{1'b0}} : tag_o;
    end
    for (int i = 0; i < NISSUE; i++) begin
      iss_match_s = (i < LANE) && issue_i[i] && (issue_rd_i[i*IDX_W +: IDX_W] == rs_i);
      val_o = iss_match_s ? tbl_val_i : val_o;
      tag_o = iss_match_s ? {TAG_BUSY, issue_rob_pos_i[i*ROB_POS_W +: ROB_POS_W]} : tag_o;
    end
    val_o = (rs_i == {IDX_W{1'b0}}) ? {DATA_W{1'b0}} : val_o;
    tag_o = (rs_i == {IDX_W{1'b0}}) ? {TAG_W{1'b0}} : tag_o;
  end

endmodule

// File: rtl/rename_regfile_mp.sv
// Multi-port register file with per-register rename tags, multi-lane issue/commit,
// rollback and a sequential register-dump engine for the test harness.
module rename_regfile_mp
  import rename_regfile_mp_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NREG      = 32,
  parameter int ROB_POS_W = 4,
  parameter int NISSUE    = 2,
  parameter int NCOMMIT   = 2,
  localparam int TAG_W    = tag_width(ROB_POS_W),
  localparam int IDX_W    = reg_pos_width(NREG),
  localparam int NRD      = 2 * NISSUE
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rdy_i,
  input  logic                         rollback_i,
  input  logic [NRD*IDX_W-1:0]         rs_i,
  output logic [NRD*DATA_W-1:0]        val_o,
  output logic [NRD*TAG_W-1:0]         rob_id_o,
  input  logic [NISSUE-1:0]            issue_i,
  input  logic [NISSUE*IDX_W-1:0]      issue_rd_i,
  input  logic [NISSUE*ROB_POS_W-1:0]  issue_rob_pos_i,
  input  logic [NCOMMIT-1:0]           commit_i,
  input  logic [NCOMMIT*IDX_W-1:0]     commit_rd_i,
  input  logic [NCOMMIT*DATA_W-1:0]    commit_val_i,
  input  logic [NCOMMIT*ROB_POS_W-1:0] commit_rob_pos_i,
  input  logic                         dump_start_i,
  output logic                         dump_busy_o,
  output logic                         dump_valid_o,
  output logic [IDX_W-1:0]             dump_idx_o,
  output logic [DATA_W-1:0]            dump_val_o
);

  logic [DATA_W-1:0]    val_q [NREG];
  logic [DATA_W-1:0]    val_d [NREG];
  logic [TAG_W-1:0]     tag_q [NREG];
  logic [TAG_W-1:0]     tag_d [NREG];
  logic [IDX_W-1:0]     cmt_rd_s  [NCOMMIT];
  logic [DATA_W-1:0]    cmt_val_s [NCOMMIT];
  logic [ROB_POS_W-1:0] cmt_pos_s [NCOMMIT];
  logic [IDX_W-1:0]     iss_rd_s  [NISSUE];
  logic [ROB_POS_W-1:0] iss_pos_s [NISSUE];
  logic [NCOMMIT-1:0]   cmt_hit_s;

  for (genvar c = 0; c < NCOMMIT; c++) begin : g_cmt
    assign cmt_rd_s[c]  = commit_rd_i[c*IDX_W +: IDX_W];
    assign cmt_val_s[c] = commit_val_i[c*DATA_W +: DATA_W];
    assign cmt_pos_s[c] = commit_rob_pos_i[c*ROB_POS_W +: ROB_POS_W];
  end

  for (genvar i = 0; i < NISSUE; i++) begin : g_iss
    assign iss_rd_s[i]  = issue_rd_i[i*IDX_W +: IDX_W];
    assign iss_pos_s[i] = issue_rob_pos_i[i*ROB_POS_W +: ROB_POS_W];
  end

  // A commit retires the newest producer only if the pre-edge tag still names its slot.
  always_comb begin
    cmt_hit_s = {NCOMMIT{1'b0}};
    for (int c = 0; c < NCOMMIT; c++) begin
      cmt_hit_s[c] = commit_i[c] && (cmt_rd_s[c] != {IDX_W{1'b0}})
                     && (tag_q[cmt_rd_s[c]] == {TAG_BUSY, cmt_pos_s[c]});
    end
  end

  // Next table: commits, then issues, then rollback; younger lanes and later steps win.
  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    for (int c = 0; c < NCOMMIT; c++) begin
      val_d[cmt_rd_s[c]] = (commit_i[c] && (cmt_rd_s[c] != {IDX_W{1'b0}}))
                           ? cmt_val_s[c] : val_d[cmt_rd_s[c]];
      tag_d[cmt_rd_s[c]] = cmt_hit_s[c] ? {TAG_W{1'b0}} : tag_d[cmt_rd_s[c]];
    end
    for (int i = 0; i < NISSUE; i++) begin
      tag_d[iss_rd_s[i]] = (issue_i[i] && (iss_rd_s[i] != {IDX_W{1'b0}}))
                           ? {TAG_BUSY, iss_pos_s[i]} : tag_d[iss_rd_s[i]];
    end
    for (int r = 0; r < NREG; r++) begin
      tag_d[r] = rollback_i ? {TAG_W{1'b0}} : tag_d[r];
    end
  end

  // Table state; register 0 is never a write target so it stays zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r] <= {DATA_W{1'b0}};
        tag_q[r] <= {TAG_W{1'b0}};
      end
    end else if (rdy_i) begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IDX_W-1:0] rs_s;
    assign rs_s = rs_i[p*IDX_W +: IDX_W];
    rename_regfile_rdport #(
      .DATA_W(DATA_W), .IDX_W(IDX_W), .ROB_POS_W(ROB_POS_W),
      .NISSUE(NISSUE), .NCOMMIT(NCOMMIT), .LANE(p / 2)
    ) u_rdport (
      .rs_i            (rs_s),
      .tbl_val_i       (val_q[rs_s]),
      .tbl_tag_i       (tag_q[rs_s]),
      .issue_i         (issue_i),
      .issue_rd_i      (issue_rd_i),
      .issue_rob_pos_i (issue_rob_pos_i),
      .cmt_hit_i       (cmt_hit_s),
      .commit_rd_i     (commit_rd_i),
      .commit_val_i    (commit_val_i),
      .val_o           (val_o[p*DATA_W +: DATA_W]),
      .tag_o           (rob_id_o[p*TAG_W +: TAG_W])
    );
  end

  dump_state_e       dump_state_q;
  logic [IDX_W-1:0]  dump_cnt_q;
  logic              dump_busy_q;
  logic              dump_valid_q;
  logic [IDX_W-1:0]  dump_idx_q;
  logic [DATA_W-1:0] dump_val_q;

  // Dump engine: one committed register per enabled cycle, holding everything when rdy is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dump_state_q <= DUMP_IDLE;
      dump_cnt_q   <= {IDX_W{1'b0}};
      dump_busy_q  <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= {IDX_W{1'b0}};
      dump_val_q   <= {DATA_W{1'b0}};
    end else if (rdy_i) begin
      case (dump_state_q)
        DUMP_IDLE: begin
          dump_valid_q <= 1'b0;
          dump_busy_q  <= dump_start_i;
          dump_cnt_q   <= {IDX_W{1'b0}};
          if (dump_start_i) begin
            dump_state_q <= DUMP_RUN;
          end
        end
        DUMP_RUN: begin
          dump_busy_q  <= 1'b1;
          dump_valid_q <= 1'b1;
          dump_idx_q   <= dump_cnt_q;
          dump_val_q   <= val_q[dump_cnt_q];
          dump_cnt_q   <= dump_cnt_q + IDX_W'(1);
          if (dump_cnt_q == IDX_W'(NREG - 1)) begin
            dump_state_q <= DUMP_IDLE;
          end
        end
        default: dump_state_q <= DUMP_IDLE;
      endcase
    end
  end

  assign dump_busy_o  = dump_busy_q;
  assign dump_valid_o = dump_valid_q;
  assign dump_idx_o   = dump_idx_q;
  assign dump_val_o   = dump_val_q;

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Bench for rename_regfile_mp: directed scenarios with literal expectations plus a
// table/dump reference model compared against every query port and dump output each cycle.
module tb_rename_regfile_mp;
  localparam int DATA_W = 32, NREG = 32, ROB_POS_W = 4, NISSUE = 2, NCOMMIT = 2;
  localparam int TAG_W = 5, IDX_W = 5, NRD = 4;

  logic clk = 1'b0;
  logic rst, rdy, rollback, dump_start, dump_busy, dump_valid;
  logic [NRD*IDX_W-1:0]         rs;
  logic [NRD*DATA_W-1:0]        val;
  logic [NRD*TAG_W-1:0]         rob_id;
  logic [NISSUE-1:0]            issue;
  logic [NISSUE*IDX_W-1:0]      issue_rd;
  logic [NISSUE*ROB_POS_W-1:0]  issue_rob_pos;
  logic [NCOMMIT-1:0]           commit;
  logic [NCOMMIT*IDX_W-1:0]     commit_rd;
  logic [NCOMMIT*DATA_W-1:0]    commit_val;
  logic [NCOMMIT*ROB_POS_W-1:0] commit_rob_pos;
  logic [IDX_W-1:0]             dump_idx;
  logic [DATA_W-1:0]            dump_val;

  always #5 clk = ~clk;

  rename_regfile_mp #(.DATA_W(DATA_W), .NREG(NREG), .ROB_POS_W(ROB_POS_W),
                      .NISSUE(NISSUE), .NCOMMIT(NCOMMIT)) dut (
    .clk_i(clk), .rst_i(rst), .rdy_i(rdy), .rollback_i(rollback),
    .rs_i(rs), .val_o(val), .rob_id_o(rob_id),
    .issue_i(issue), .issue_rd_i(issue_rd), .issue_rob_pos_i(issue_rob_pos),
    .commit_i(commit), .commit_rd_i(commit_rd), .commit_val_i(commit_val),
    .commit_rob_pos_i(commit_rob_pos), .dump_start_i(dump_start),
    .dump_busy_o(dump_busy), .dump_valid_o(dump_valid),
    .dump_idx_o(dump_idx), .dump_val_o(dump_val)
  );

  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;
  logic [31:0] m_val [NREG];
  logic [4:0]  m_tag [NREG];
  bit          md_active;
  int          md_cnt;
  logic        e_busy, e_valid;
  logic [4:0]  e_idx;
  logic [31:0] e_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_val(input int p);
    return val[p*DATA_W +: DATA_W];
  endfunction

  function automatic logic [31:0] dut_tag(input int p);
    return {27'd0, rob_id[p*TAG_W +: TAG_W]};
  endfunction

  task automatic set_q(input int p, input int r);
    rs[p*IDX_W +: IDX_W] = r[4:0];
  endtask

  task automatic set_iss(input int l, input int rd, input int pos);
    issue[l] = 1'b1;
    issue_rd[l*IDX_W +: IDX_W] = rd[4:0];
    issue_rob_pos[l*ROB_POS_W +: ROB_POS_W] = pos[3:0];
  endtask

  task automatic set_cmt(input int l, input int rd, input int pos, input logic [31:0] v);
    commit[l] = 1'b1;
    commit_rd[l*IDX_W +: IDX_W] = rd[4:0];
    commit_rob_pos[l*ROB_POS_W +: ROB_POS_W] = pos[3:0];
    commit_val[l*DATA_W +: DATA_W] = v;
  endtask

  task automatic clear_in();
    rollback = 1'b0; dump_start = 1'b0; rs = '0;
    issue = '0; issue_rd = '0; issue_rob_pos = '0;
    commit = '0; commit_rd = '0; commit_val = '0; commit_rob_pos = '0;
  endtask

  // Expected query result: search the first matching rule, youngest lane first.
  function automatic void model_query(input int p, output logic [31:0] v,
                                      output logic [31:0] t, output bit vcare);
    int r, k, crd;
    bit hit;
    r = int'(rs[p*IDX_W +: IDX_W]);
    k = p / 2;
    v = m_val[r]; t = {27'd0, m_tag[r]}; vcare = 1'b1; hit = 1'b0;
    if (r == 0) begin
      v = 32'd0; t = 32'd0;
      return;
    end
    for (int i = k - 1; i >= 0 && !hit; i--) begin
      if (issue[i] && int'(issue_rd[i*IDX_W +: IDX_W]) == r) begin
        t = 32'h10 | {28'd0, issue_rob_pos[i*ROB_POS_W +: ROB_POS_W]};
        vcare = 1'b0; hit = 1'b1;
      end
    end
    if (hit) return;
    for (int c = NCOMMIT - 1; c >= 0 && !hit; c--) begin
      crd = int'(commit_rd[c*IDX_W +: IDX_W]);
      if (commit[c] && crd != 0 && crd == r
          && m_tag[crd] == {1'b1, commit_rob_pos[c*ROB_POS_W +: ROB_POS_W]}) begin
        v = commit_val[c*DATA_W +: DATA_W]; t = 32'd0; hit = 1'b1;
      end
    end
  endfunction

  // Advance one clock: derive the post-edge model from current inputs, then cross the edge.
  task automatic tick();
    logic [31:0] nv [NREG];
    logic [4:0]  nt [NREG];
    bit na; int nc, rd;
    logic nb, nvld; logic [4:0] ni; logic [31:0] nd;
    nv = m_val; nt = m_tag; na = md_active; nc = md_cnt;
    nb = e_busy; nvld = e_valid; ni = e_idx; nd = e_val;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin nv[r] = 32'd0; nt[r] = 5'd0; end
      na = 1'b0; nc = 0; nb = 1'b0; nvld = 1'b0; ni = 5'd0; nd = 32'd0;
    end else if (rdy) begin
      for (int c = 0; c < NCOMMIT; c++) begin
        rd = int'(commit_rd[c*IDX_W +: IDX_W]);
        if (commit[c] && rd != 0) begin
          nv[rd] = commit_val[c*DATA_W +: DATA_W];
          if (m_tag[rd] == {1'b1, commit_rob_pos[c*ROB_POS_W +: ROB_POS_W]}) nt[rd] = 5'd0;
        end
      end
      for (int i = 0; i < NISSUE; i++) begin
        rd = int'(issue_rd[i*IDX_W +: IDX_W]);
        if (issue[i] && rd != 0) nt[rd] = {1'b1, issue_rob_pos[i*ROB_POS_W +: ROB_POS_W]};
      end
      if (rollback) for (int r = 0; r < NREG; r++) nt[r] = 5'd0;
      if (md_active) begin
        nb = 1'b1; nvld = 1'b1; ni = md_cnt[4:0]; nd = m_val[md_cnt];
        if (md_cnt == NREG - 1) na = 1'b0;
        else nc = md_cnt + 1;
      end else begin
        nvld = 1'b0; nb = dump_start;
        if (dump_start) begin na = 1'b1; nc = 0; end
      end
    end
    @(posedge clk);
    m_val = nv; m_tag = nt; md_active = na; md_cnt = nc;
    e_busy = nb; e_valid = nvld; e_idx = ni; e_val = nd;
    #1;
  endtask

  // Every-cycle comparison of all query ports and dump outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NRD; p++) begin
        logic [31:0] ev, et;
        bit vc;
        model_query(p, ev, et, vc);
        check($sformatf("q_tag[%0d]", p), dut_tag(p), et);
        if (vc) check($sformatf("q_val[%0d]", p), dut_val(p), ev);
      end
      check("dump_busy", 32'(dump_busy), 32'(e_busy));
      check("dump_valid", 32'(dump_valid), 32'(e_valid));
      if (e_valid) begin
        check("dump_idx", 32'(dump_idx), 32'(e_idx));
        check("dump_val", dump_val, e_val);
      end
    end
  end

  initial begin
    bit reached, held;
    int rd, pos;
    rst = 1'b1; rdy = 1'b1; clear_in();
    for (int r = 0; r < NREG; r++) begin m_val[r] = 32'd0; m_tag[r] = 5'd0; end
    md_active = 1'b0; md_cnt = 0; e_busy = 1'b0; e_valid = 1'b0; e_idx = 5'd0; e_val = 32'd0;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;

    set_q(0, 5); @(negedge clk);
    check("rst_x5_val", dut_val(0), 32'h0); check("rst_x5_tag", dut_tag(0), 32'h0);
    check("rst_busy", 32'(dump_busy), 32'h0); check("rst_valid", 32'(dump_valid), 32'h0);
    check("rst_idx", 32'(dump_idx), 32'h0); check("rst_dval", dump_val, 32'h0);
    tick();

    clear_in(); set_cmt(0, 0, 0, 32'hDEAD); set_q(0, 0); @(negedge clk);
    check("x0_same_val", dut_val(0), 32'h0); check("x0_same_tag", dut_tag(0), 32'h0); tick();
    clear_in(); set_q(0, 0); @(negedge clk);
    check("x0_after_val", dut_val(0), 32'h0); tick();

    clear_in(); set_iss(0, 3, 4); set_q(2, 3); set_q(0, 3); @(negedge clk);
    check("byp_p2_tag", dut_tag(2), 32'h14); check("nobyp_p0_tag", dut_tag(0), 32'h0); tick();
    clear_in(); set_q(0, 3); @(negedge clk);
    check("x3_tag", dut_tag(0), 32'h14); tick();

    clear_in(); set_iss(0, 7, 2); tick();
    clear_in(); set_cmt(0, 7, 2, 32'h55); set_q(0, 7); @(negedge clk);
    check("cmt_byp_val", dut_val(0), 32'h55); check("cmt_byp_tag", dut_tag(0), 32'h0); tick();
    clear_in(); set_q(0, 7); @(negedge clk);
    check("x7_val", dut_val(0), 32'h55); check("x7_tag", dut_tag(0), 32'h0); tick();
    clear_in(); set_iss(1, 7, 3); tick();
    clear_in(); set_cmt(1, 7, 1, 32'h66); set_q(0, 7); @(negedge clk);
    check("stale_byp_val", dut_val(0), 32'h55); check("stale_byp_tag", dut_tag(0), 32'h13); tick();
    clear_in(); set_q(0, 7); @(negedge clk);
    check("stale_val", dut_val(0), 32'h66); check("stale_tag", dut_tag(0), 32'h13); tick();

    clear_in(); set_cmt(0, 9, 0, 32'h11); set_cmt(1, 9, 1, 32'h22); set_iss(0, 9, 6); tick();
    clear_in(); set_q(0, 9); @(negedge clk);
    check("x9_val", dut_val(0), 32'h22); check("x9_tag", dut_tag(0), 32'h16); tick();

    clear_in(); set_iss(0, 4, 5); tick();
    clear_in(); rollback = 1'b1; set_iss(1, 4, 8); set_cmt(0, 4, 5, 32'h99); tick();
    clear_in(); set_q(0, 4); set_q(1, 9); @(negedge clk);
    check("rb_x4_val", dut_val(0), 32'h99); check("rb_x4_tag", dut_tag(0), 32'h0);
    check("rb_x9_tag", dut_tag(1), 32'h0); tick();

    // Mixed traffic with a dump running underneath; the model checks every cycle.
    clear_in(); dump_start = 1'b1; tick();
    for (int n = 0; n < 60; n++) begin
      clear_in();
      rdy = ($urandom_range(0, 7) != 0);
      rollback = ($urandom_range(0, 15) == 0);
      dump_start = (n == 10);
      for (int l = 0; l < NISSUE; l++)
        if ($urandom_range(0, 1) == 1) set_iss(l, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      for (int l = 0; l < NCOMMIT; l++) begin
        if ($urandom_range(0, 1) == 1) begin
          rd = int'($urandom_range(0, 15));
          pos = ($urandom_range(0, 1) == 1) ? int'(m_tag[rd][3:0]) : int'($urandom_range(0, 15));
          set_cmt(l, rd, pos, $urandom);
        end
      end
      for (int p = 0; p < NRD; p++) begin
        set_q(p, int'($urandom_range(0, 15)));
        if (p >= 2 && $urandom_range(0, 1) == 1) set_q(p, int'(issue_rd[4:0]));
      end
      tick();
    end
    clear_in(); rdy = 1'b1;
    repeat (40) tick();

    // Second dump: start timing, rdy hold at idx 5, reset at idx 10.
    clear_in(); dump_start = 1'b1; tick();
    clear_in(); @(negedge clk);
    check("d_busy_start", 32'(dump_busy), 32'h1); check("d_valid_start", 32'(dump_valid), 32'h0);
    tick(); @(negedge clk);
    check("d_first_valid", 32'(dump_valid), 32'h1); check("d_first_idx", 32'(dump_idx), 32'h0);
    reached = 1'b0; held = 1'b0;
    for (int n = 0; n < 80 && !reached; n++) begin
      if (e_valid && e_idx == 5'd5 && !held) begin
        held = 1'b1; rdy = 1'b0;
        repeat (3) begin
          tick(); @(negedge clk);
          check("d_hold_idx", 32'(dump_idx), 32'h5); check("d_hold_valid", 32'(dump_valid), 32'h1);
        end
        rdy = 1'b1; tick(); @(negedge clk);
      end else if (e_valid && e_idx == 5'd10) begin
        reached = 1'b1; rst = 1'b1; tick(); rst = 1'b0; @(negedge clk);
        check("d_rst_busy", 32'(dump_busy), 32'h0); check("d_rst_valid", 32'(dump_valid), 32'h0);
        check("d_rst_idx", 32'(dump_idx), 32'h0);
      end else begin
        tick(); @(negedge clk);
      end
    end
    check("d_reach_idx10", 32'(reached), 32'h1);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
